// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_pkg
//  Description : Shared sizing constants and the read-format opcode encoding
//                for the word/byte/bit memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

   localparam int DEPTH  = 256;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   // Read format select carried on RdEn_Opcode
   typedef enum logic [1:0] {
      RD_WORD = 2'd0,
      RD_BYTE = 2'd1,
      RD_BIT  = 2'd2,
      RD_ID   = 2'd3
   } rd_op_e;

endpackage
`default_nettype wire

// File: rtl/memory_rd_format.sv
`default_nettype none
// ============================================================================
//  Module      : memory_rd_format
//  Description : Combinational read-data formatter. Turns a stored word into
//                a full word, a zero-extended byte lane, a zero-extended
//                single bit, or the word XORed with an identifier.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_rd_format
   import memory_pkg::*;
(
   input  logic [DATA_W-1:0] i_word,
   input  rd_op_e            i_opcode,
   input  logic [1:0]        i_byteAddr,
   input  logic [4:0]        i_bitAddr,
   input  logic [DATA_W-1:0] i_studentId,
   output logic [DATA_W-1:0] o_formatted
);

   logic [7:0] w_byteLane;

   // Select one of the four byte lanes; lane 0 is the least significant byte
   always_comb begin
      w_byteLane = i_word[7:0];
      case (i_byteAddr)
         2'd0: w_byteLane = i_word[7:0];
         2'd1: w_byteLane = i_word[15:8];
         2'd2: w_byteLane = i_word[23:16];
         2'd3: w_byteLane = i_word[31:24];
         default: w_byteLane = i_word[7:0];
      endcase
   end

   // Build the formatted read value; unused upper bits are always zero
   always_comb begin
      o_formatted = '0;
      case (i_opcode)
         RD_WORD: o_formatted = i_word;
         RD_BYTE: o_formatted = {{(DATA_W-8){1'b0}}, w_byteLane};
         RD_BIT:  o_formatted = {{(DATA_W-1){1'b0}}, i_word[i_bitAddr]};
         RD_ID:   o_formatted = i_word ^ i_studentId;
         default: o_formatted = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/word_byte_bit_memory.sv
`default_nettype none
// ============================================================================
//  Module      : word_byte_bit_memory
//  Description : 256 x 32 synchronous single-port RAM with a registered,
//                opcode-selected read formatter (word / byte / bit / ID-XOR).
//                Read is read-before-write on a same-address collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_byte_bit_memory
#(
   parameter int DEPTH  = memory_pkg::DEPTH,
   parameter int DATA_W = memory_pkg::DATA_W
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          WrEn,
   input  logic                          RdEn,
   input  logic [1:0]                    RdEn_Opcode,
   input  logic [memory_pkg::ADDR_W-1:0] Addr,
   input  logic [1:0]                    ByteAddr,
   input  logic [7:0]                    BitAddr,
   input  logic [DATA_W-1:0]             WrBus,
   input  logic [DATA_W-1:0]             StudentId,
   output logic [DATA_W-1:0]             RdBus
);

   import memory_pkg::*;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdBus;
   logic [DATA_W-1:0] w_formatted;

   // Only BitAddr[4:0] addresses a bit in a 32-bit word; the rest is don't-care
   logic w_unusedBitAddr;
   assign w_unusedBitAddr = &{1'b0, BitAddr[7:5]};

   memory_rd_format u_rdFormat (
      .i_word      (r_mem[Addr]),
      .i_opcode    (rd_op_e'(RdEn_Opcode)),
      .i_byteAddr  (ByteAddr),
      .i_bitAddr   (BitAddr[4:0]),
      .i_studentId (StudentId),
      .o_formatted (w_formatted)
   );

   // Storage and read register: the read samples the pre-write contents, so a
   // same-edge write to the read address becomes visible on the next read
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdBus <= '0;
      end else begin
         if (WrEn) begin
            r_mem[Addr] <= WrBus;
         end
         if (RdEn) begin
            r_rdBus <= w_formatted;
         end
      end
   end

   assign RdBus = r_rdBus;

endmodule
`default_nettype wire

// File: tb/tb_word_byte_bit_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_byte_bit_memory
//  Description : Self-checking bench for word_byte_bit_memory. A plain array
//                reference model predicts RdBus for directed and random ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_byte_bit_memory;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        WrEn = 1'b0;
   logic        RdEn = 1'b0;
   logic [1:0]  RdEn_Opcode = 2'd0;
   logic [7:0]  Addr = 8'd0;
   logic [1:0]  ByteAddr = 2'd0;
   logic [7:0]  BitAddr = 8'd0;
   logic [31:0] WrBus = 32'd0;
   logic [31:0] StudentId = 32'd0;
   logic [31:0] RdBus;

   int          nTests = 0;
   int          nFails = 0;

   logic [31:0] refMem [256];
   logic [31:0] expRd = 32'd0;

   word_byte_bit_memory dut (
      .clk         (clk),
      .reset       (reset),
      .WrEn        (WrEn),
      .RdEn        (RdEn),
      .RdEn_Opcode (RdEn_Opcode),
      .Addr        (Addr),
      .ByteAddr    (ByteAddr),
      .BitAddr     (BitAddr),
      .WrBus       (WrBus),
      .StudentId   (StudentId),
      .RdBus       (RdBus)
   );

   always #5 clk = ~clk;

   task automatic checkResult(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference read: plain shifts and masks on the stored word
   function automatic logic [31:0] refRead(input logic [31:0] w, input logic [1:0] op,
                                           input logic [1:0] ba, input logic [7:0] bi,
                                           input logic [31:0] sid);
      int sh;
      case (op)
         2'd0: return w;
         2'd1: begin sh = 8 * int'(ba); return (w >> sh) & 32'hFF; end
         2'd2: begin sh = int'(bi) % 32; return (w >> sh) & 32'h1; end
         default: return w ^ sid;
      endcase
   endfunction

   // One clock of stimulus, then model update and RdBus check
   task automatic cyc(input logic rst, input logic wr, input logic rd, input logic [1:0] op,
                      input logic [7:0] a, input logic [1:0] ba, input logic [7:0] bi,
                      input logic [31:0] wd, input logic [31:0] sid);
      @(negedge clk);
      reset = rst; WrEn = wr; RdEn = rd; RdEn_Opcode = op; Addr = a;
      ByteAddr = ba; BitAddr = bi; WrBus = wd; StudentId = sid;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 256; i++) refMem[i] = 32'd0;
         expRd = 32'd0;
      end else begin
         if (rd) expRd = refRead(refMem[a], op, ba, bi, sid);
         if (wr) refMem[a] = wd;
      end
      #1;
      checkResult("rdbus_model", RdBus, expRd);
   endtask

   task automatic wr1(input logic [7:0] a, input logic [31:0] d);
      cyc(1'b0, 1'b1, 1'b0, 2'd0, a, 2'd0, 8'd0, d, 32'd0);
   endtask

   task automatic rd1(input logic [1:0] op, input logic [7:0] a, input logic [1:0] ba,
                      input logic [7:0] bi, input logic [31:0] sid);
      cyc(1'b0, 1'b0, 1'b1, op, a, ba, bi, 32'd0, sid);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) refMem[i] = 32'd0;

      // Power-on reset
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 8'd0, 32'd0, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 8'd0, 32'd0, 32'd0);
      checkResult("reset_rdbus", RdBus, 32'h0);

      // Reset clears memory and RdBus; WrEn/RdEn ignored during reset
      wr1(8'd7, 32'hFFFF_FFFF);
      rd1(2'd0, 8'd7, 2'd0, 8'd0, 32'd0);
      checkResult("pre_reset_read", RdBus, 32'hFFFF_FFFF);
      cyc(1'b1, 1'b1, 1'b1, 2'd0, 8'd7, 2'd0, 8'd0, 32'h1234_5678, 32'd0);
      checkResult("reset_clears_rdbus", RdBus, 32'h0);
      rd1(2'd0, 8'd7, 2'd0, 8'd0, 32'd0);
      checkResult("reset_clears_mem", RdBus, 32'h0);

      // Fill and read back every address
      for (int i = 0; i < 256; i++) wr1(8'(i), 32'(i));
      for (int i = 0; i < 256; i++) begin
         rd1(2'd0, 8'(i), 2'd0, 8'd0, 32'd0);
         checkResult("fill_readback", RdBus, 32'(i));
      end

      // Byte lanes
      wr1(8'h10, 32'hA1B2_C3D4);
      rd1(2'd1, 8'h10, 2'd0, 8'd0, 32'd0); checkResult("byte0", RdBus, 32'h0000_00D4);
      rd1(2'd1, 8'h10, 2'd1, 8'd0, 32'd0); checkResult("byte1", RdBus, 32'h0000_00C3);
      rd1(2'd1, 8'h10, 2'd2, 8'd0, 32'd0); checkResult("byte2", RdBus, 32'h0000_00B2);
      rd1(2'd1, 8'h10, 2'd3, 8'd0, 32'd0); checkResult("byte3", RdBus, 32'h0000_00A1);

      // Single bits, including upper BitAddr bits being ignored
      rd1(2'd2, 8'h10, 2'd0, 8'h04, 32'd0); checkResult("bit4", RdBus, 32'h1);
      rd1(2'd2, 8'h10, 2'd0, 8'h03, 32'd0); checkResult("bit3", RdBus, 32'h0);
      rd1(2'd2, 8'h10, 2'd0, 8'h3F, 32'd0); checkResult("bit3F", RdBus, 32'h1);
      rd1(2'd2, 8'h10, 2'd0, 8'hE3, 32'd0); checkResult("bitE3", RdBus, 32'h0);

      // ID-tagged word
      wr1(8'd5, 32'h0000_0005);
      rd1(2'd3, 8'd5, 2'd0, 8'd0, 32'd200108828);
      checkResult("id_read", RdBus, 32'h0BED_6B19);

      // Hold: RdEn low for 3 cycles while writes occur, including the read address
      rd1(2'd0, 8'h10, 2'd0, 8'd0, 32'd0);
      checkResult("hold_start", RdBus, 32'hA1B2_C3D4);
      wr1(8'h10, 32'h1111_1111); checkResult("hold1", RdBus, 32'hA1B2_C3D4);
      wr1(8'h20, 32'h2222_2222); checkResult("hold2", RdBus, 32'hA1B2_C3D4);
      wr1(8'h30, 32'h3333_3333); checkResult("hold3", RdBus, 32'hA1B2_C3D4);

      // Collision: read returns old data, next read returns new
      wr1(8'd9, 32'h1);
      cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'd9, 2'd0, 8'd0, 32'h2, 32'd0);
      checkResult("collide_old", RdBus, 32'h1);
      rd1(2'd0, 8'd9, 2'd0, 8'd0, 32'd0);
      checkResult("collide_new", RdBus, 32'h2);

      // Randomized traffic on a narrow address window to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 199) == 0),
             1'($urandom), 1'($urandom), 2'($urandom),
             8'($urandom_range(0, 15)), 2'($urandom), 8'($urandom),
             $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/word_byte_bit_memory.md
Name: word_byte_bit_memory

Overview:
- 256-entry x 32-bit synchronous single-port RAM with a registered read-data formatter.
- Reads return a full word, a selected byte, a selected bit, or the word XOR-tagged with a per-instance identifier, chosen by a 2-bit read opcode.
- Used as a lab-level data store that test infrastructure fills and reads back word by word.

Parameters:
- DEPTH, 256, number of 32-bit words; address width is 8 bits.
- DATA_W, 32, word width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- WrEn  input  1  write enable.
- RdEn  input  1  read enable.
- RdEn_Opcode  input  2  read format select: 00 word, 01 byte, 10 bit, 11 ID-tagged word.
- Addr  input  8  word address, shared by read and write.
- ByteAddr  input  2  byte lane select for opcode 01; 0 selects bits [7:0].
- BitAddr  input  8  bit select for opcode 10; only BitAddr[4:0] is used, BitAddr[7:5] is ignored.
- WrBus  input  32  write data.
- StudentId  input  32  identifier XORed into opcode-11 reads.
- RdBus  output  32  registered read data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- On reset:
  - All 256 words clear to 0.
  - RdBus clears to 0.
  - WrEn and RdEn are ignored during the reset cycle.
- Write:
  - If WrEn=1 at a rising edge, mem[Addr] <= WrBus.
  - No byte enables; the full word is written.
- Read:
  - If RdEn=1 at a rising edge, RdBus is updated at that edge from mem[Addr] (latency 1 cycle).
  - Opcode 00: RdBus <= mem[Addr].
  - Opcode 01: RdBus <= {24'b0, mem[Addr][8*ByteAddr +: 8]}.
  - Opcode 10: RdBus <= {31'b0, mem[Addr][BitAddr[4:0]]}.
  - Opcode 11: RdBus <= mem[Addr] ^ StudentId.
- RdEn=0: RdBus holds its previous value.
- Simultaneous WrEn=1 and RdEn=1:
  - Both take effect.
  - The read is read-before-write and returns the old contents of mem[Addr].
  - The new data is visible from the next read onward.
- Address range: every 8-bit value is valid. No wrap or out-of-range condition exists.
- RdBus has no X propagation; X on unused BitAddr bits must not affect the result.
- Latched inputs: RdEn_Opcode, ByteAddr, BitAddr and StudentId are sampled at the read edge only.

Decomposition:
- Shared package memory_pkg holds:
  - Localparams DEPTH, DATA_W and ADDR_W=8.
  - A 2-bit enum rd_op_e with values RD_WORD=0, RD_BYTE=1, RD_BIT=2, RD_ID=3.
- One sub-module, memory_rd_format, is natural.
  - It is purely combinational.
  - Inputs: word, opcode, ByteAddr, BitAddr[4:0], StudentId. Output: formatted 32-bit value.
  - The top module registers its output into RdBus.

Test Plan:
- Reset clear: write 0xFFFFFFFF to addr 7, assert reset 1 cycle, then read addr 7 with opcode 00 -> RdBus=0x00000000. RdBus is 0 in the cycle after reset.
- Fill/readback: write mem[i]=i for i=0..255 (one per cycle), then read i=0..255 with opcode 00 -> RdBus==i one cycle after each read edge, with zero mismatches.
- Byte read: write 0xA1B2C3D4 to addr 0x10, read with opcode 01:
  - ByteAddr=0 -> 0x000000D4
  - ByteAddr=1 -> 0x000000C3
  - ByteAddr=2 -> 0x000000B2
  - ByteAddr=3 -> 0x000000A1
- Bit read: same word at 0x10, read with opcode 10:
  - BitAddr=4 -> 0x00000001
  - BitAddr=3 -> 0x00000000
  - BitAddr=0x3F (uses bit 31) -> 0x00000001
- ID read: StudentId=200108828 (0x0BED6B1C), mem[5]=0x00000005, read with opcode 11 -> 0x0BED6B19.
- Hold and collision:
  - With RdEn=0, RdBus stays at its last value across 3 cycles while writes occur.
  - WrEn=RdEn=1 on addr 9 holding 0x1, writing 0x2, gives RdBus=0x1; the next read gives 0x2.
